// File: rtl/periodic_event_gen.sv
// periodic_event_gen: multi-channel periodic tick generator with repeat/forever modes, stop, global pause and done strobes.
module periodic_event_gen #(
  parameter int CHANNELS = 4,
  parameter int PER_W    = 8,
  parameter int REP_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       start_i,
  input  logic [CHANNELS-1:0]       stop_i,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS*PER_W-1:0] period_i,
  input  logic [CHANNELS*REP_W-1:0] count_i,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       done_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic                      any_busy_o
);
  typedef enum logic {IDLE, RUN} state_e;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e           state_q, state_d;
    logic             mode_q, mode_d, tick_q, tick_d, done_q, done_d;
    logic [PER_W-1:0] per_q, per_d, ph_q, ph_d, per_in;
    logic [REP_W-1:0] rem_q, rem_d;
    logic             run, live, zero, fire, fin, go, load;
    always_comb begin
      per_in  = period_i[c*PER_W +: PER_W] == '0 ? PER_W'(1) : period_i[c*PER_W +: PER_W];
      go      = start_i[c] & ~stop_i[c];
      run     = state_q == RUN;
      live    = run & ~stop_i[c];
      zero    = run & ~mode_q & (rem_q == '0);
      fire    = live & ~zero & en & (ph_q == PER_W'(1));
      // a finishing channel may be restarted on the same edge, so back-to-back runs leave no gap
      fin     = (live & zero) | (fire & ~mode_q & (rem_q == REP_W'(1)));
      load    = (~run | fin) & go;
      state_d = (load | (live & ~fin)) ? RUN : IDLE;
      mode_d  = load ? mode_i[c] : mode_q;
      per_d   = load ? per_in : per_q;
      ph_d    = load ? per_in : (live & en & ~zero) ? (fire ? per_q : ph_q - PER_W'(1)) : ph_q;
      rem_d   = load ? count_i[c*REP_W +: REP_W] : (fire & ~mode_q) ? rem_q - REP_W'(1) : rem_q;
      tick_d  = fire;
      done_d  = fin;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        mode_q  <= 1'b0;
        per_q   <= '0;
        ph_q    <= '0;
        rem_q   <= '0;
        tick_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        mode_q  <= mode_d;
        per_q   <= per_d;
        ph_q    <= ph_d;
        rem_q   <= rem_d;
        tick_q  <= tick_d;
        done_q  <= done_d;
      end
    end
    assign tick_o[c] = tick_q;
    assign done_o[c] = done_q;
    assign busy_o[c] = state_q == RUN;
  end
  assign any_busy_o = |busy_o;
endmodule

// File: tb/tb_periodic_event_gen.sv
// tb_periodic_event_gen: directed and randomized checks of periodic_event_gen against an elapsed-cycle model.
module tb_periodic_event_gen;
  localparam int CH = 4, PW = 8, RW = 8;
  logic clk = 0, rst = 1, en = 1;
  logic [CH-1:0] start_i = '0, stop_i = '0, mode_i = '0;
  logic [CH*PW-1:0] period_i = '0;
  logic [CH*RW-1:0] count_i = '0;
  logic [CH-1:0] tick_o, done_o, busy_o;
  logic any_busy_o;
  int vectors = 0, errs = 0;
  bit chk = 0;

  periodic_event_gen #(.CHANNELS(CH), .PER_W(PW), .REP_W(RW)) dut (
    .clk(clk), .rst(rst), .en(en), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .period_i(period_i), .count_i(count_i), .tick_o(tick_o), .done_o(done_o),
    .busy_o(busy_o), .any_busy_o(any_busy_o));

  always #5 clk = ~clk;

  // Model: a run is described by how many enabled cycles have elapsed since its start;
  // tick n falls when that count reaches n*P, and a repeat run ends at tick R.
  bit act[CH], md[CH];
  int per[CH], rc[CH], el[CH];
  logic [CH-1:0] x_tick = '0, x_done = '0, x_busy = '0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) act[i] = 0;
      x_tick = '0; x_done = '0; x_busy = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit fin;
        fin = 0; x_tick[i] = 0; x_done[i] = 0;
        if (act[i]) begin
          if (stop_i[i]) act[i] = 0;
          else if (!md[i] && rc[i] == 0) begin x_done[i] = 1; fin = 1; end
          else if (en) begin
            el[i]++;
            if (el[i] % per[i] == 0) begin
              x_tick[i] = 1;
              if (!md[i] && el[i] / per[i] == rc[i]) begin x_done[i] = 1; fin = 1; end
            end
          end
        end
        if ((!act[i] || fin) && start_i[i] && !stop_i[i]) begin
          act[i] = 1; md[i] = mode_i[i]; el[i] = 0;
          per[i] = period_i[i*PW +: PW] == 0 ? 1 : int'(period_i[i*PW +: PW]);
          rc[i] = int'(count_i[i*RW +: RW]);
        end else if (fin) act[i] = 0;
        x_busy[i] = act[i];
      end
    end
  end

  always @(negedge clk) if (chk) begin
    vectors++;
    if (tick_o !== x_tick) begin errs++; $display("FAIL tick t=%0t got %b exp %b", $time, tick_o, x_tick); end
    if (done_o !== x_done) begin errs++; $display("FAIL done t=%0t got %b exp %b", $time, done_o, x_done); end
    if (busy_o !== x_busy) begin errs++; $display("FAIL busy t=%0t got %b exp %b", $time, busy_o, x_busy); end
    if (any_busy_o !== |x_busy) begin errs++; $display("FAIL any_busy t=%0t got %b exp %b", $time, any_busy_o, |x_busy); end
  end

  task automatic lit(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin errs++; $display("FAIL %s got %0d exp %0d", name, act_v, exp_v); end
  endtask

  task automatic set_ch(input int c, input logic m, input int p, input int n);
    mode_i[c] = m; period_i[c*PW +: PW] = PW'(p); count_i[c*RW +: RW] = RW'(n);
  endtask

  task automatic go(input logic [CH-1:0] s);
    start_i = s; @(negedge clk); start_i = '0;
  endtask

  initial begin
    int n, dn, mask;
    repeat (2) @(negedge clk);
    chk = 1; rst = 0;
    lit("rst_busy", busy_o, 0); lit("rst_tick", tick_o, 0); lit("rst_done", done_o, 0);
    // repeat P=5 R=20
    set_ch(0, 0, 5, 20); go(4'b0001);
    lit("t1_busy0", busy_o[0], 1);
    n = 0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk); n += tick_o[0];
      if (j == 5) lit("t1_first", tick_o[0], 1);
      if (j == 99) lit("t1_busy99", busy_o[0], 1);
    end
    lit("t1_ticks", n, 20); lit("t1_done", done_o[0], 1); lit("t1_idle", busy_o[0], 0);
    // forever P=5, stop at k+52
    set_ch(1, 1, 5, 0); go(4'b0010);
    n = 0; dn = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk); n += tick_o[1]; dn += done_o[1];
      if (j == 51) begin lit("t2_busy51", busy_o[1], 1); stop_i[1] = 1; end
      if (j == 52) begin lit("t2_busy52", busy_o[1], 0); stop_i[1] = 0; end
    end
    lit("t2_ticks", n, 10); lit("t2_nodone", dn, 0);
    // repeat P=3 R=4 with 4-cycle pause after tick 2
    set_ch(2, 0, 3, 4); go(4'b0100);
    mask = 0;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk); if (tick_o[2]) mask |= 1 << j;
      if (j == 16) lit("t3_done", done_o[2], 1);
      if (j == 6) en = 0;
      if (j == 10) en = 1;
    end
    lit("t3_mask", mask, 73800);
    // period 0 count 3
    set_ch(3, 0, 0, 3); go(4'b1000);
    mask = 0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk); if (tick_o[3]) mask |= 1 << j;
      if (j == 3) lit("t4_done", done_o[3], 1);
    end
    lit("t4_mask", mask, 14);
    // count 0
    set_ch(0, 0, 4, 0); go(4'b0001);
    lit("t5_busy0", busy_o[0], 1);
    @(negedge clk);
    lit("t5_done", done_o[0], 1); lit("t5_notick", tick_o[0], 0); lit("t5_idle", busy_o[0], 0);
    // start and stop on the same edge
    set_ch(1, 0, 2, 2); stop_i[1] = 1; go(4'b0010); stop_i[1] = 0;
    lit("t6_idle", busy_o[1], 0);
    repeat (3) @(negedge clk);
    // restart at the done edge with start held high
    set_ch(0, 0, 2, 2); start_i[0] = 1;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 4) begin lit("t7_done", done_o[0], 1); lit("t7_busy", busy_o[0], 1); end
      if (j == 6) begin lit("t7_tick", tick_o[0], 1); start_i[0] = 0; end
    end
    lit("t7_done2", done_o[0], 1); lit("t7_idle", busy_o[0], 0);
    // four channels, staggered starts, mid-run start pulse on ch3
    set_ch(0, 0, 2, 3); set_ch(1, 0, 3, 3); set_ch(2, 0, 4, 3); set_ch(3, 0, 7, 3);
    go(4'b0001); go(4'b0010); go(4'b0100); go(4'b1000);
    repeat (2) @(negedge clk);
    go(4'b1000);
    repeat (4) @(negedge clk);
    lit("t8_ch3_tick7", tick_o[3], 1);
    repeat (3) @(negedge clk);
    lit("t8_ch3_no10", tick_o[3], 0);
    repeat (20) @(negedge clk);
    // reset mid-run, then a normal start
    set_ch(0, 1, 3, 0); set_ch(1, 0, 2, 9); go(4'b0011);
    repeat (4) @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    lit("t9_busy", busy_o, 0); lit("t9_done", done_o, 0); lit("t9_tick", tick_o, 0);
    set_ch(2, 0, 2, 1); go(4'b0100);
    repeat (2) @(negedge clk);
    lit("t9_tick2", tick_o[2], 1); lit("t9_done2", done_o[2], 1);
    // randomized traffic
    for (int j = 0; j < 4000; j++) begin
      for (int i = 0; i < CH; i++) begin
        start_i[i] = $urandom_range(0, 3) == 0;
        stop_i[i]  = $urandom_range(0, 40) == 0;
        set_ch(i, $urandom_range(0, 3) == 0, $urandom_range(0, 6), $urandom_range(0, 4));
      end
      en  = $urandom_range(0, 7) != 0;
      rst = j == 2000;
      @(negedge clk);
    end
    rst = 0; start_i = '0; stop_i = '0; en = 1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/periodic_event_gen.md
# periodic_event_gen

Multi-channel, cycle-accurate event generator: the synthesizable successor to our simulation-only `repeat`/`forever` loop demos. Each channel, once started, emits a one-cycle `tick` every `period` clocks, either a programmed number of times (repeat mode) or until stopped (forever mode). It is parametrised in channel count and counter widths, and adds stop, global pause and completion signalling. It sits beside test sequencers and timer logic as the common source of periodic strobes.

## Interface
- `CHANNELS`, default 4: number of independent channels.
- `PER_W`, default 8: period counter width; the maximum period is 2^PER_W-1.
- `REP_W`, default 8: repeat count width; the maximum count is 2^REP_W-1.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global run enable; low = pause all channels.
- `start_i`  in  CHANNELS  per-channel start request, sampled each edge.
- `stop_i`  in  CHANNELS  per-channel stop request, sampled each edge.
- `mode_i`  in  CHANNELS  0 = repeat, 1 = forever; latched at start.
- `period_i`  in  CHANNELS*PER_W  per-channel period; channel i uses bits [i*PER_W +: PER_W]; latched at start.
- `count_i`  in  CHANNELS*REP_W  per-channel repeat count; channel i uses bits [i*REP_W +: REP_W]; latched at start; ignored in forever mode.
- `tick_o`  out  CHANNELS  one-cycle event strobe.
- `done_o`  out  CHANNELS  one-cycle completion strobe (repeat mode only).
- `busy_o`  out  CHANNELS  channel is in RUN.
- `any_busy_o`  out  1  OR of `busy_o`.

## Operation
- Each channel has a two-state FSM: IDLE and RUN. Channel state consists of a phase counter (PER_W bits), a remaining-count register (REP_W bits), and the latched mode and period.
- IDLE -> RUN when `start_i[i]`=1 and `stop_i[i]`=0.
  - On entry, latch mode, period and count, and load phase = latched period.
  - A `period_i` of 0 is latched as 1.
  - Start is accepted regardless of `en`.
- RUN with `en`=1: phase decrements each edge.
  - When phase reaches 0, issue a tick and reload phase = latched period.
  - Repeat mode: remaining decrements on each tick. The tick that takes remaining to 0 also raises `done_o` and returns the channel to IDLE.
  - Forever mode: ticks continue indefinitely and `done_o` is never raised.
- RUN with `en`=0: phase and remaining hold, and no tick is issued. Stop still takes effect while paused.
- Repeat mode with count 0: the channel accepts start and enters RUN. On the next edge it raises `done_o` and returns to IDLE, with no tick issued. `en` is ignored for this case.
- `stop_i[i]`=1 in RUN: the channel goes to IDLE at that edge. No tick and no done are issued at or after that edge, and the remaining count is discarded.
- `start_i` while in RUN is ignored; no restart occurs.
- Start and stop asserted on the same edge: stop wins. In IDLE this means no start; in RUN it means a stop.
- Channels are fully independent. Start, stop and tick events on different channels may coincide.
- Reset takes priority over all inputs. After reset every channel is in IDLE, all counters are 0, and all outputs are 0.

## Timing
- All outputs are registered.
- Let a start be sampled at edge k.
  - `busy_o` is high from edge k.
  - Tick n (n = 1, 2, ...) is high for the one cycle following edge k + n*P, where P = effective period, assuming `en` stays high.
- Each low-`en` cycle during RUN delays all later ticks by one cycle.
- Repeat mode with count R ≥ 1:
  - `done_o` is coincident with the R-th tick, after edge k + R*P.
  - `busy_o` falls after the same edge.
  - A new start is accepted at that same edge, so back-to-back runs leave no gap.
- Repeat mode with count 0: `done_o` is high after edge k+1, and `busy_o` is high for exactly one cycle.
- P = 1: `tick_o` is high every cycle while running.
- Stop sampled at edge m: `busy_o` and `tick_o` are 0 after edge m, including a tick that was due at edge m.
- Reset asserted mid-run: all outputs are 0 after that edge, and no `done_o` is issued.

## Test plan
- Channel 0, repeat mode, period 5, count 20, `en` held at 1 → 20 ticks at edges k+5 … k+100; `done_o` with the 20th tick; `busy_o` low after edge k+100.
- Channel 1, forever mode, period 5, stop at edge k+52 → ticks at k+5 … k+50 only (10 ticks); no `done_o`; `busy_o` low after edge k+52.
- Channel 2, repeat mode, period 3, count 4, with `en`=0 for 4 cycles after the 2nd tick → ticks at k+3, k+6, k+13, k+16; `done_o` at k+16.
- Edge cases:
  - Period 0 with count 3 → ticks on 3 consecutive cycles.
  - Count 0 → `done_o` at k+1 and no tick.
  - Start and stop on the same edge → the channel stays IDLE.
- All 4 channels, each started at a different edge with periods 2, 3, 4, 7:
  - Tick patterns are independent.
  - A re-start at the `done_o` edge begins a new run with no gap.
  - A `start_i` pulse mid-run is ignored.
- Reset asserted mid-run → all outputs 0 on the next cycle; a start after reset behaves normally.
